load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface. Sits between the CPU MEM stage and `Data_Memory`, turning byte/half/word load-store requests into word-indexed memory accesses. Adds wait-state counting for a configurable memory latency, byte-lane extraction with sign/zero extension, alignment checking, and read-modify-write for sub-word stores. Stalls the pipeline while a request is in flight.

## Interface
- `MEM_LAT`, default 1: cycles `mem_read_o` is held before read data is sampled (legal 1..7).
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  request present.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed_i`  in  1  load sign-extends when 1; ignored for word loads and stores.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_ready_o`  out  1  high only in IDLE.
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_rdata_o`  out  32  extended load data; valid with `resp_valid_o` on loads, 0 otherwise.
- `misalign_o`  out  1  qualifies `resp_valid_o`: request rejected, no memory access.
- `stall_o`  out  1  pipeline stall.
- `mem_addr_o`  out  32  word index `{2'b00, addr[31:2]}`.
- `mem_data_o`  out  32  write word.
- `mem_write_o`  out  1  memory write strobe.
- `mem_read_o`  out  1  memory read strobe.
- `mem_data_i`  in  32  memory read data (registered inside memory, valid one edge after read).

## Operation
- States: IDLE, RD, CAP, WR, RMW_WR, RESP.
- Acceptance: `req_valid_i && req_ready_o` at an IDLE edge. All `req_*` are latched; the requester may change them afterwards.
- Alignment: a half requires addr[0]=0; a word requires addr[1:0]=0; size 11 is always an error. Error -> RESP with `misalign_o`=1 and no memory strobe.
- Word store: IDLE -> WR (`mem_write_o`=1, `mem_data_o`=wdata) -> RESP.
- Load: IDLE -> RD (`mem_read_o`=1 for MEM_LAT cycles) -> CAP (sample `mem_data_i`, extract, register into `resp_rdata_o`) -> RESP.
- Sub-word store: IDLE -> RD (MEM_LAT cycles) -> CAP (latch old word) -> RMW_WR (`mem_write_o`=1, merged word) -> RESP.
- Lanes are little-endian. The byte at addr[1:0]=n occupies bits [8n+7:8n]. The half at addr[1]=h occupies bits [16h+15:16h]. A merge replaces only the addressed lane(s).
- Extension: signed loads replicate the lane MSB; unsigned loads zero-fill.
- RESP: `resp_valid_o`=1 for exactly one cycle, then IDLE. There is no backpressure.
- `mem_addr_o` is stable from the acceptance edge until return to IDLE. `mem_data_o` is 0 outside WR/RMW_WR.
- `mem_read_o` and `mem_write_o` are never high together.
- `stall_o = (IDLE && req_valid_i) || state ∉ {IDLE, RESP}`.

## Timing
- Reset (any state): next state is IDLE. All outputs are 0 except `req_ready_o`=1.
- A reset during RD/CAP aborts the request with no write, so memory is unchanged. A reset edge in RMW_WR/WR clears the strobe at that edge.
- All timing is relative to acceptance edge 0:
  - Misaligned: RESP at edge 0.
  - Word store: WR at edge 0, RESP at edge 1.
  - Load: RD at edges 0..MEM_LAT-1, CAP at edge MEM_LAT, RESP at edge MEM_LAT+1.
  - Sub-word store: as load, then RMW_WR at edge MEM_LAT+1 and RESP at edge MEM_LAT+2.
- Back-to-back: the next request can be accepted at the edge ending RESP+1 (first IDLE cycle). Throughput is at most one request per (latency+2) cycles.
- MEM_LAT counter is 3 bits. It is cleared on entry to RD and does not wrap within a request.

## Configuration
- `LSU_RMW_EN` defined: sub-word stores use the RMW path above.
- Undefined: sub-word stores are rejected like misaligned requests (RESP at edge 0, `misalign_o`=1, no memory access). The RMW_WR state and merge logic are not compiled. Loads of all sizes are unaffected.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 (MEM_LAT=1) -> `mem_addr_o`=4; `resp_rdata_o`=0xDEADBEEF with `resp_valid_o` 2 edges after load acceptance.
- Memory word 0x80FF7F01: signed byte loads @0,1,2,3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Unsigned half @2 -> 0x000080FF.
- `LSU_RMW_EN`: word 0x11223344 @0x20, byte store 0xAA @0x21 -> memory 0x1122AA44, exactly one `mem_write_o` pulse at edge MEM_LAT+1.
- Half load @0x3 and word store @0x2 -> `misalign_o`=1 with `resp_valid_o` at edge 0, no `mem_read_o`/`mem_write_o`.
- MEM_LAT=4 load: `mem_read_o` high 4 cycles, `stall_o` high from acceptance through CAP, low in RESP.
- `rst_i`=0 during RD of an RMW byte store -> IDLE next edge, outputs reset, target word unchanged on readback.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory interface.
// Turns byte/half/word load-store requests into word-indexed memory accesses.
// It adds MEM_LAT wait states, lane extraction with sign/zero extension and
// alignment checking. The pipeline is stalled while a request is in flight.
// Optional feature macro LSU_RMW_EN enables read-modify-write for sub-word
// stores. Without it, sub-word stores are rejected through misalign_o.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   req_valid_i/req_write_i/req_size_i/req_signed_i/req_addr_i/req_wdata_i : request
//   req_ready_o, resp_valid_o, resp_rdata_o, misalign_o, stall_o       : response/pipeline
//   mem_addr_o (word index), mem_data_o, mem_write_o, mem_read_o, mem_data_i : memory
module load_store_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   input  logic        req_write_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        req_ready_o,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        misalign_o,
   output logic        stall_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        mem_write_o,
   output logic        mem_read_o,
   input  logic [31:0] mem_data_i
);
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP
`ifdef LSU_RMW_EN
      , RMW_WR
`endif
   } state_t;
   localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
   state_t      state_q;
   logic [2:0]  cnt_q;
   logic [1:0]  size_q, off_q;
   logic        signed_q, rd_q, wr_q, valid_q, mis_q;
   logic [31:0] addr_q, mdata_q, rdata_q, rdata_d;
   logic [15:0] lane;
   logic [4:0]  sh;
   logic        err_d;
`ifdef LSU_RMW_EN
   logic        write_q;
   logic [31:0] wdata_q, mask, merge_d;
`endif
   always_comb begin
      err_d = (&req_size_i) | (req_size_i == 2'b01 & req_addr_i[0]) | (req_size_i == 2'b10 & |req_addr_i[1:0])
`ifndef LSU_RMW_EN
            | (req_write_i & ~req_size_i[1])
`endif
            ;
      // a legal half always has off_q[0]=0, so one byte-granular shift serves both sizes
      sh = {off_q, 3'b000};
      lane = 16'(mem_data_i >> sh);
      rdata_d = size_q == 2'b00 ? {{24{signed_q & lane[7]}}, lane[7:0]} :
                size_q == 2'b01 ? {{16{signed_q & lane[15]}}, lane} : mem_data_i;
`ifdef LSU_RMW_EN
      mask = size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
      merge_d = (mem_data_i & ~(mask << sh)) | ((wdata_q & mask) << sh);
`endif
   end
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         size_q   <= '0;
         off_q    <= '0;
         signed_q <= 1'b0;
         addr_q   <= '0;
         mdata_q  <= '0;
         rdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         valid_q  <= 1'b0;
         mis_q    <= 1'b0;
`ifdef LSU_RMW_EN
         write_q  <= 1'b0;
         wdata_q  <= '0;
`endif
      end else begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         mdata_q <= '0;
         rdata_q <= '0;
         case (state_q)
            IDLE: if (req_valid_i) begin
               size_q   <= req_size_i;
               off_q    <= req_addr_i[1:0];
               signed_q <= req_signed_i;
               addr_q   <= {2'b00, req_addr_i[31:2]};
`ifdef LSU_RMW_EN
               write_q  <= req_write_i;
               wdata_q  <= req_wdata_i;
`endif
               if (err_d) begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  mis_q   <= 1'b1;
               end else if (req_write_i && req_size_i == 2'b10) begin
                  state_q <= WR;
                  wr_q    <= 1'b1;
                  mdata_q <= req_wdata_i;
               end else begin
                  state_q <= RD;
                  rd_q    <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            RD: if (cnt_q == LAST) state_q <= CAP;
               else begin
                  cnt_q <= cnt_q + 3'd1;
                  rd_q  <= 1'b1;
               end
            CAP:
`ifdef LSU_RMW_EN
               if (write_q) begin
                  state_q <= RMW_WR;
                  wr_q    <= 1'b1;
                  mdata_q <= merge_d;
               end else
`endif
               begin
                  state_q <= RESP;
                  valid_q <= 1'b1;
                  rdata_q <= rdata_d;
               end
`ifdef LSU_RMW_EN
            WR, RMW_WR: begin
`else
            WR: begin
`endif
               state_q <= RESP;
               valid_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign req_ready_o  = state_q == IDLE;
   assign stall_o      = (state_q == IDLE && req_valid_i) || !(state_q == IDLE || state_q == RESP);
   assign resp_valid_o = valid_q;
   assign resp_rdata_o = rdata_q;
   assign misalign_o   = mis_q;
   assign mem_addr_o   = addr_q;
   assign mem_data_o   = mdata_q;
   assign mem_write_o  = wr_q;
   assign mem_read_o   = rd_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: drives MEM_LAT=1 and MEM_LAT=4 instances against a byte-level reference model.
module tb_load_store_unit;
`ifdef LSU_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst [2];
   logic        vld [2];
   logic        wr, sg, clr;
   logic [1:0]  sz;
   logic [31:0] ad, wd;
   logic        rdy [2], rv [2], mis [2], stl [2], mw [2], mr [2];
   logic [31:0] rdat [2], maddr [2], mdo [2], mdi [2];
   logic [31:0] mem [2][16];
   logic [7:0]  gb [2][64];
   int n_cmp = 0, n_bad = 0;
   for (genvar g = 0; g < 2; g++) begin : u
      load_store_unit #(.MEM_LAT(g == 0 ? 1 : 4)) dut (
         .clk_i(clk), .rst_i(rst[g]), .req_valid_i(vld[g]), .req_write_i(wr), .req_size_i(sz),
         .req_signed_i(sg), .req_addr_i(ad), .req_wdata_i(wd), .req_ready_o(rdy[g]),
         .resp_valid_o(rv[g]), .resp_rdata_o(rdat[g]), .misalign_o(mis[g]), .stall_o(stl[g]),
         .mem_addr_o(maddr[g]), .mem_data_o(mdo[g]), .mem_write_o(mw[g]), .mem_read_o(mr[g]),
         .mem_data_i(mdi[g]));
   end
   always @(posedge clk)
      for (int g = 0; g < 2; g++)
         if (clr) for (int i = 0; i < 16; i++) mem[g][i] <= '0;
         else begin
            if (mr[g]) mdi[g] <= mem[g][maddr[g][3:0]];
            if (mw[g]) mem[g][maddr[g][3:0]] <= mdo[g];
         end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic int nbytes(input logic [1:0] s);
      return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
   endfunction
   function automatic logic [31:0] gload(input int uu, input logic [5:0] a, input logic [1:0] s, input bit sgn);
      int n = nbytes(s);
      longint v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(gb[uu][int'(a) + i]) << (8 * i));
      if (sgn && n < 4 && gb[uu][int'(a) + n - 1][7]) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction
   function automatic logic [31:0] gword(input int uu, input int j);
      return {gb[uu][4*j+3], gb[uu][4*j+2], gb[uu][4*j+1], gb[uu][4*j]};
   endfunction
   function automatic bit misal(input logic [1:0] s, input logic [31:0] a, input bit w);
      return s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || (!RMW && w && s != 2'd2);
   endfunction
   task automatic drive(input int uu, input bit w, input logic [1:0] s, input bit sgn, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      chk("ready", rdy[uu], 1);
      vld[uu] = 1'b1; wr = w; sz = s; sg = sgn; ad = a; wd = d;
      #1 chk("stall_req", stl[uu], 1);
      @(posedge clk);
      #1;
      vld[uu] = 1'b0; wr = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom); ad = $urandom; wd = $urandom;
   endtask
   task automatic do_req(input int uu, input bit w, input logic [1:0] s, input bit sgn, input logic [31:0] a, input logic [31:0] d);
      int lat = uu != 0 ? 4 : 1;
      bit e = misal(s, a, w);
      int exp_k = e ? 0 : (w && s == 2'd2) ? 1 : w ? lat + 2 : lat + 1;
      logic [31:0] exp_rd = (!e && !w) ? gload(uu, a[5:0], s, sgn) : 32'd0;
      logic [31:0] wi = {2'b00, a[31:2]};
      int k, nr = 0, nw = 0, both = 0, bst = 0, badr = 0, bmd = 0;
      bit seen = 0;
      drive(uu, w, s, sgn, a, d);
      for (k = 0; k < 20; k++) begin
         if (mr[uu]) nr++;
         if (mw[uu]) nw++;
         if (mr[uu] && mw[uu]) both++;
         if (stl[uu] !== !rv[uu]) bst++;
         if (maddr[uu] !== wi) badr++;
         if (!mw[uu] && mdo[uu] !== 32'd0) bmd++;
         if (rv[uu]) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("resp_seen", seen, 1);
      chk("latency", k, exp_k);
      chk("misalign", mis[uu], e);
      chk("rdata", rdat[uu], exp_rd);
      chk("n_read", nr, (!e && !(w && s == 2'd2)) ? lat : 0);
      chk("n_write", nw, (w && !e) ? 1 : 0);
      chk("rd_wr_excl", both, 0);
      chk("stall", bst, 0);
      chk("mem_addr", badr, 0);
      chk("mem_data_idle", bmd, 0);
      @(posedge clk);
      #1 chk("back_idle", {rv[uu], rdy[uu], mr[uu], mw[uu]}, 4'b0100);
      if (w && !e) begin
         for (int i = 0; i < nbytes(s); i++) gb[uu][int'(a[5:0]) + i] = d[8*i +: 8];
         chk("mem_word", mem[uu][a[5:2]], gword(uu, int'(a[5:2])));
      end
   endtask
   task automatic rst_mid(input int uu);
      drive(uu, 1'b1, 2'd0, 1'b0, 32'h21, 32'h5A);
      @(negedge clk);
      rst[uu] = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_ctl", {rdy[uu], rv[uu], mis[uu], stl[uu], mr[uu], mw[uu]}, 6'b100000);
      chk("rst_data", {rdat[uu], maddr[uu]}, 64'd0);
      chk("rst_mdo", mdo[uu], 32'd0);
      rst[uu] = 1'b1;
      do_req(uu, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int g = 0; g < 2; g++) begin
         rst[g] = 1'b0; vld[g] = 1'b0;
         for (int i = 0; i < 64; i++) gb[g][i] = 8'd0;
      end
      wr = 0; sg = 0; sz = 0; ad = 0; wd = 0; clr = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("reset_ctl", {rdy[g], rv[g], mis[g], stl[g], mr[g], mw[g]}, 6'b100000);
         chk("reset_data", {rdat[g], maddr[g]}, 64'd0);
         chk("reset_mdo", mdo[g], 32'd0);
         rst[g] = 1'b1;
      end
      clr = 1'b0;
      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 16; i++) do_req(g, 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
         do_req(g, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
         do_req(g, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
         do_req(g, 1'b1, 2'd2, 1'b0, 32'h0, 32'h80FF7F01);
         for (int i = 0; i < 4; i++) do_req(g, 1'b0, 2'd0, 1'b1, 32'(i), 32'd0);
         do_req(g, 1'b0, 2'd1, 1'b0, 32'h2, 32'd0);
         do_req(g, 1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344);
         do_req(g, 1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA);
         do_req(g, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
         do_req(g, 1'b1, 2'd1, 1'b0, 32'h26, 32'hFFFF9876);
         do_req(g, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0);
         do_req(g, 1'b0, 2'd1, 1'b0, 32'h3, 32'd0);
         do_req(g, 1'b1, 2'd2, 1'b0, 32'h2, 32'h12345678);
         do_req(g, 1'b0, 2'd3, 1'b0, 32'h8, 32'd0);
         rst_mid(g);
         for (int i = 0; i < 40; i++)
            do_req(g, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
